// File: rtl/issue_unit.sv
// issue_unit: issue arbiter for int, ld/st, mult and div execution queues.
// The CDB is scheduled at issue time so that completions never collide. The
// CDB output register serves as slot 0. res_q[k] (k = 1..DIV_LAT-1) holds a
// CDB claim k cycles ahead, which gives DIV_LAT slots in total. A div claim
// lands at distance DIV_LAT, beyond the stored slots. That target is always
// free, so a div only has to wait for the divider to be idle.
// Optional: define ISSUE_STALL_CNT_EN to build the stall-cycle counter.
module issue_unit #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_int_ready,
  input  logic        i_ld_st_ready,
  input  logic        i_mult_ready,
  input  logic        i_div_ready,
  input  logic        i_flush,
  output logic        o_int_issue,
  output logic        o_ld_st_issue,
  output logic        o_mult_issue,
  output logic        o_div_issue,
  output logic        o_cdb_valid,
  output logic [1:0]  o_cdb_src,
  output logic        o_div_busy,
  output logic [15:0] o_stall_cnt
);

  localparam int NSLOT = DIV_LAT - 1;
  localparam logic [1:0] SRC_INT  = 2'd0;
  localparam logic [1:0] SRC_LDST = 2'd1;
  localparam logic [1:0] SRC_MULT = 2'd2;
  localparam logic [1:0] SRC_DIV  = 2'd3;

  logic [NSLOT:1]      res_vld_q, res_vld_d;
  logic [NSLOT:1][1:0] res_src_q, res_src_d;
  logic                cdb_vld_q, cdb_vld_d;
  logic [1:0]          cdb_src_q, cdb_src_d;
  logic                rr_q, rr_d;          // 0: int favoured, 1: ld/st favoured
  logic [4:0]          div_cnt_q, div_cnt_d;

  logic issue_ok, int_can, ld_can;

  // Issue is blocked entirely during reset and flush.
  assign issue_ok = i_rst_n & ~i_flush;

  // Int and ld/st both target slot 1, so they compete for a single grant.
  assign int_can = i_int_ready   & ~res_vld_q[1] & issue_ok;
  assign ld_can  = i_ld_st_ready & ~res_vld_q[1] & issue_ok;

  assign o_int_issue   = int_can & (~ld_can | ~rr_q);
  assign o_ld_st_issue = ld_can  & (~int_can | rr_q);
  assign o_mult_issue  = i_mult_ready & ~res_vld_q[MULT_LAT] & issue_ok;
  assign o_div_issue   = i_div_ready & ~o_div_busy & issue_ok;

  assign o_div_busy  = (div_cnt_q != 5'd0);
  assign o_cdb_valid = cdb_vld_q;
  assign o_cdb_src   = cdb_src_q;

  // Shift the reservations down one slot and insert this cycle's claims.
  always_comb begin
    res_vld_d = '0;
    res_src_d = '0;
    for (int k = 1; k < NSLOT; k++) begin
      res_vld_d[k] = res_vld_q[k+1];
      res_src_d[k] = res_src_q[k+1];
    end
    cdb_vld_d = res_vld_q[1];
    cdb_src_d = res_src_q[1];
    if (o_int_issue | o_ld_st_issue) begin
      cdb_vld_d = 1'b1;
      cdb_src_d = o_ld_st_issue ? SRC_LDST : SRC_INT;
    end
    if (o_mult_issue) begin
      res_vld_d[MULT_LAT-1] = 1'b1;
      res_src_d[MULT_LAT-1] = SRC_MULT;
    end
    if (o_div_issue) begin
      res_vld_d[NSLOT] = 1'b1;
      res_src_d[NSLOT] = SRC_DIV;
    end
    // A flush discards all in-flight results, including the next CDB cycle.
    if (i_flush) begin
      res_vld_d = '0;
      res_src_d = '0;
      cdb_vld_d = 1'b0;
      cdb_src_d = SRC_INT;
    end
  end

  // The round-robin pointer moves only after a contested grant. The divider
  // busy window counts down from DIV_LAT after each div issue.
  always_comb begin
    rr_d = rr_q ^ (int_can & ld_can);
    div_cnt_d = div_cnt_q;
    if (i_flush)                 div_cnt_d = 5'd0;
    else if (o_div_issue)        div_cnt_d = 5'(DIV_LAT);
    else if (div_cnt_q != 5'd0)  div_cnt_d = div_cnt_q - 5'd1;
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_vld_q <= '0;
      res_src_q <= '0;
      cdb_vld_q <= 1'b0;
      cdb_src_q <= 2'd0;
      rr_q      <= 1'b0;
      div_cnt_q <= 5'd0;
    end else begin
      res_vld_q <= res_vld_d;
      res_src_q <= res_src_d;
      cdb_vld_q <= cdb_vld_d;
      cdb_src_q <= cdb_src_d;
      rr_q      <= rr_d;
      div_cnt_q <= div_cnt_d;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        any_ready, any_issue;

  assign any_ready = i_int_ready | i_ld_st_ready | i_mult_ready | i_div_ready;
  assign any_issue = o_int_issue | o_ld_st_issue | o_mult_issue | o_div_issue;

  // Saturating count of cycles in which work was ready but nothing issued.
  always_comb begin
    stall_d = stall_q;
    if (any_ready & ~any_issue & ~i_flush & (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_q <= 16'd0;
    else          stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit using the default MULT_LAT=4 and DIV_LAT=8.
// A CDB monitor schedules each observed issue at its latency. It then checks
// o_cdb_valid/o_cdb_src every cycle and flags any two claims on the same cycle.
module tb_issue_unit;
  localparam int ML = 4;
  localparam int DL = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_int_ready = 1'b0, i_ld_st_ready = 1'b0;
  logic        i_mult_ready = 1'b0, i_div_ready = 1'b0, i_flush = 1'b0;
  logic        o_int_issue, o_ld_st_issue, o_mult_issue, o_div_issue;
  logic        o_cdb_valid, o_div_busy;
  logic [1:0]  o_cdb_src;
  logic [15:0] o_stall_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  issue_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_int_ready(i_int_ready), .i_ld_st_ready(i_ld_st_ready),
    .i_mult_ready(i_mult_ready), .i_div_ready(i_div_ready), .i_flush(i_flush),
    .o_int_issue(o_int_issue), .o_ld_st_issue(o_ld_st_issue),
    .o_mult_issue(o_mult_issue), .o_div_issue(o_div_issue),
    .o_cdb_valid(o_cdb_valid), .o_cdb_src(o_cdb_src),
    .o_div_busy(o_div_busy), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // CDB scoreboard: bit 2 is valid and bits 1:0 are the expected source.
  logic [2:0] exp_cdb [0:63];

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 64; k++) exp_cdb[k] = 3'b0;
    end else begin
      checks++;
      if (o_cdb_valid !== exp_cdb[cyc%64][2] ||
          (exp_cdb[cyc%64][2] && o_cdb_src !== exp_cdb[cyc%64][1:0])) begin
        errors++;
        $display("FAIL cdb_mon cyc=%0d got v=%0b src=%0d exp v=%0b src=%0d", cyc,
                 o_cdb_valid, o_cdb_src, exp_cdb[cyc%64][2], exp_cdb[cyc%64][1:0]);
      end
      exp_cdb[cyc%64] = 3'b0;
      if (i_flush) for (int k = 0; k < 64; k++) exp_cdb[k] = 3'b0;
      if (o_int_issue)   claim(cyc + 1,  2'd0);
      if (o_ld_st_issue) claim(cyc + 1,  2'd1);
      if (o_mult_issue)  claim(cyc + ML, 2'd2);
      if (o_div_issue)   claim(cyc + DL, 2'd3);
    end
  end

  task automatic claim(input int at, input logic [1:0] src);
    checks++;
    if (exp_cdb[at%64][2] !== 1'b0) begin
      errors++;
      $display("FAIL slot_collision cyc=%0d got claim src=%0d on owned slot, exp free", at, src);
    end
    exp_cdb[at%64] = {1'b1, src};
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    #1 i_rst_n = 1'b0;
    i_int_ready = 1'b1; i_div_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_int_issue, o_ld_st_issue, o_mult_issue, o_div_issue} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000",
        {o_int_issue, o_ld_st_issue, o_mult_issue, o_div_issue});
    end
    checks++;
    if ({o_cdb_valid, o_cdb_src, o_div_busy} !== 4'b0 || o_stall_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_state got v=%0b src=%0d busy=%0b stall=%0d exp all 0",
        o_cdb_valid, o_cdb_src, o_div_busy, o_stall_cnt);
    end
    step();
    i_int_ready = 1'b0; i_div_ready = 1'b0;
    i_rst_n = 1'b1;
  endtask

  task automatic test_single_int();
    step(); i_int_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_int_issue !== 1'b1) begin
      errors++; $display("FAIL int_issue got %0b exp 1", o_int_issue);
    end
    step(); i_int_ready = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_cdb_valid !== 1'b1 || o_cdb_src !== 2'd0 || o_int_issue !== 1'b0) begin
      errors++; $display("FAIL int_cdb got v=%0b src=%0d iss=%0b exp v=1 src=0 iss=0",
        o_cdb_valid, o_cdb_src, o_int_issue);
    end
  endtask

  task automatic test_rr();
    logic ei, el;
    logic [1:0] es;
    step(); i_int_ready = 1'b1; i_ld_st_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin i_int_ready = 1'b0; i_ld_st_ready = 1'b0; end
      @(negedge i_clk);
      ei = (i < 4) && (i % 2 == 0);
      el = (i < 4) && (i % 2 == 1);
      checks++;
      if (o_int_issue !== ei || o_ld_st_issue !== el) begin
        errors++; $display("FAIL rr_grant i=%0d got int=%0b ld=%0b exp int=%0b ld=%0b",
          i, o_int_issue, o_ld_st_issue, ei, el);
      end
      if (i > 0) begin
        es = ((i - 1) % 2 == 1) ? 2'd1 : 2'd0;
        checks++;
        if (o_cdb_valid !== 1'b1 || o_cdb_src !== es) begin
          errors++; $display("FAIL rr_cdb i=%0d got v=%0b src=%0d exp v=1 src=%0d",
            i, o_cdb_valid, o_cdb_src, es);
        end
      end
      step();
    end
  endtask

  task automatic test_mult_block();
    logic ei;
    step(); i_int_ready = 1'b1; i_mult_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (i == 0) begin
        checks++;
        if (o_mult_issue !== 1'b1) begin
          errors++; $display("FAIL mult_issue got %0b exp 1", o_mult_issue);
        end
      end
      ei = (i != 3);
      checks++;
      if (o_int_issue !== ei) begin
        errors++; $display("FAIL mult_blocks_int i=%0d got %0b exp %0b", i, o_int_issue, ei);
      end
      if (i == 4) begin
        checks++;
        if (o_cdb_valid !== 1'b1 || o_cdb_src !== 2'd2) begin
          errors++; $display("FAIL mult_cdb got v=%0b src=%0d exp v=1 src=2", o_cdb_valid, o_cdb_src);
        end
      end
      step();
      i_mult_ready = 1'b0;
    end
    i_int_ready = 1'b0;
  endtask

  task automatic test_div();
    logic eb, ed;
    step(); i_div_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_div_issue !== 1'b1 || o_div_busy !== 1'b0) begin
      errors++; $display("FAIL div_issue got iss=%0b busy=%0b exp iss=1 busy=0", o_div_issue, o_div_busy);
    end
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 10) i_div_ready = 1'b0;
      @(negedge i_clk);
      eb = (i <= 8) || (i >= 10 && i <= 17);
      ed = (i == 9);
      checks++;
      if (o_div_busy !== eb || o_div_issue !== ed) begin
        errors++; $display("FAIL div_busy i=%0d got busy=%0b iss=%0b exp busy=%0b iss=%0b",
          i, o_div_busy, o_div_issue, eb, ed);
      end
      if (i == 8 || i == 17) begin
        checks++;
        if (o_cdb_valid !== 1'b1 || o_cdb_src !== 2'd3) begin
          errors++; $display("FAIL div_cdb i=%0d got v=%0b src=%0d exp v=1 src=3", i, o_cdb_valid, o_cdb_src);
        end
      end
    end
  endtask

  task automatic test_flush();
    step(); i_div_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_div_issue !== 1'b1) begin
      errors++; $display("FAIL flush_div_issue got %0b exp 1", o_div_issue);
    end
    step(); i_div_ready = 1'b0;
    step(); i_flush = 1'b1; i_int_ready = 1'b1; i_mult_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_int_issue, o_ld_st_issue, o_mult_issue, o_div_issue} !== 4'b0) begin
      errors++; $display("FAIL flush_strobes got %b exp 0000",
        {o_int_issue, o_ld_st_issue, o_mult_issue, o_div_issue});
    end
    step(); i_flush = 1'b0; i_int_ready = 1'b0; i_mult_ready = 1'b0;
    for (int i = 3; i <= 9; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_div_busy !== 1'b0 || o_cdb_valid !== 1'b0) begin
        errors++; $display("FAIL flush_clear t0+%0d got busy=%0b v=%0b exp 0 0", i, o_div_busy, o_cdb_valid);
      end
      step();
    end
  endtask

  task automatic test_reset_abandon();
    i_div_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_div_issue !== 1'b1) begin
      errors++; $display("FAIL rst_div_issue got %0b exp 1", o_div_issue);
    end
    step(); i_div_ready = 1'b0;
    step(); i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_div_busy !== 1'b0 || o_stall_cnt !== 16'h0) begin
      errors++; $display("FAIL rst_async got busy=%0b stall=%0d exp 0 0", o_div_busy, o_stall_cnt);
    end
    step(); i_rst_n = 1'b1;
    for (int i = 3; i <= 10; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_cdb_valid !== 1'b0 || o_div_busy !== 1'b0) begin
        errors++; $display("FAIL rst_abandon t0+%0d got v=%0b busy=%0b exp 0 0", i, o_cdb_valid, o_div_busy);
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [15:0] es;
    for (int n = 0; n < 3; n++) begin
      i_div_ready = 1'b1;
      @(negedge i_clk);
      checks++;
      if (o_div_issue !== 1'b1) begin
        errors++; $display("FAIL stall_div_issue n=%0d got %0b exp 1", n, o_div_issue);
      end
      step(); i_div_ready = 1'b0;
      step(); step(); step();
      i_mult_ready = 1'b1;
      @(negedge i_clk);
      checks++;
      if (o_mult_issue !== 1'b0) begin
        errors++; $display("FAIL stall_mult_blocked n=%0d got %0b exp 0", n, o_mult_issue);
      end
      step(); i_mult_ready = 1'b0;
      for (int w = 0; w < 5; w++) step();
    end
`ifdef ISSUE_STALL_CNT_EN
    es = 16'd3;
`else
    es = 16'd0;
`endif
    @(negedge i_clk);
    checks++;
    if (o_stall_cnt !== es) begin
      errors++; $display("FAIL stall_cnt got %0d exp %0d", o_stall_cnt, es);
    end
  endtask

  initial begin
    test_reset();
    test_single_int();
    test_rr();
    test_mult_block();
    test_div();
    test_flush();
    test_reset_abandon();
    test_stall();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4, multiplier latency in cycles, issue to CDB write, legal range 2..DIV_LAT-1.
REQ-002 SHALL have parameter DIV_LAT, default 8, divider latency in cycles, non-pipelined, legal range MULT_LAT+1..16.
REQ-003 SHALL have port i_clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports i_int_ready, i_ld_st_ready, i_mult_ready, i_div_ready, input, 1 bit each: the matching exec queue is non-empty and its head operands are ready.
REQ-006 SHALL have port i_flush, input, 1 bit: pipeline flush.
REQ-007 SHALL have ports o_int_issue, o_ld_st_issue, o_mult_issue, o_div_issue, output, 1 bit each: single-cycle pop/issue strobe to the matching queue (its rd_en).
REQ-008 SHALL have port o_cdb_valid, output, 1 bit: a unit drives the CDB this cycle.
REQ-009 SHALL have port o_cdb_src, output, 2 bits: CDB owner this cycle; 0 int, 1 ld/st, 2 mult, 3 div.
REQ-010 SHALL have port o_div_busy, output, 1 bit: the divider is occupied.
REQ-011 SHALL have port o_stall_cnt, output, 16 bits: stall-cycle counter (see Configuration).

Function
REQ-012 SHALL keep a CDB reservation shift register of DIV_LAT slots, each slot holding a valid bit and a 2-bit source tag; slot k means the CDB is claimed k cycles ahead.
REQ-013 SHALL shift the reservation register down by one slot every cycle; slot 1 is registered into o_cdb_valid/o_cdb_src.
REQ-014 SHALL give int and ld/st latency 1, mult latency MULT_LAT and div latency DIV_LAT; issue at cycle t SHALL drive the CDB at cycle t+latency.
REQ-015 SHALL permit an issue only when ready is high, the target slot is free after this cycle's shift, and i_flush is low.
REQ-016 SHALL issue to the divider only when o_div_busy is low.
REQ-017 SHALL set o_div_busy on a div issue and hold it until the div result cycle, so o_div_busy is high for exactly DIV_LAT cycles.
REQ-018 SHALL allow div, mult and one of int/ld_st to issue in the same cycle, since they target distinct slots.
REQ-019 SHALL let only one of int and ld/st issue per cycle, chosen round-robin with a 1-bit pointer; reset favours int, and the pointer toggles only when the favoured requester is granted against competition.
REQ-020 SHALL write each issuing unit's tag into its target slot in the cycle of issue.
REQ-021 SHALL never write two units into the same slot; a bench assertion checks this.
REQ-022 SHALL, on i_flush, suppress all issue strobes that cycle, clear every reservation slot and o_div_busy next cycle, and hold the round-robin pointer.
REQ-023 SHALL drive the issue strobes combinationally from the current inputs and state, with zero-cycle grant latency.

Reset
REQ-024 SHALL, on i_rst_n low, asynchronously clear all slots, o_cdb_valid, o_cdb_src=0, o_div_busy, the div counter, the RR pointer (int) and o_stall_cnt.
REQ-025 SHALL hold all issue strobes at 0 while reset is asserted; reset during an in-flight div SHALL abandon that div with no CDB cycle.

Configuration
REQ-026 SHALL, when macro ISSUE_STALL_CNT_EN is defined, increment o_stall_cnt each cycle any ready is high and no issue occurs, flush cycles excluded, saturating at 16'hFFFF.
REQ-027 SHALL, when ISSUE_STALL_CNT_EN is undefined, tie o_stall_cnt to 16'h0000 and omit the counter logic.

Verification
REQ-028 SHALL cover: int_ready=1 only at t0 -> o_int_issue=1 at t0, and o_cdb_valid=1 with src=0 at t0+1.
REQ-029 SHALL cover: int_ready and ld_st_ready held high for 4 cycles -> strobes alternate int, ld/st, int, ld/st, and the CDB src sequence is 0,1,0,1.
REQ-030 SHALL cover: mult issued at t0 (MULT_LAT=4) with int_ready high -> int is blocked at t0+3 only, the CDB shows src 2 at t0+4, and int issues at t0+4.
REQ-031 SHALL cover: div issued at t0 and div_ready kept high -> o_div_busy is high t0+1..t0+8, the next div issue is no earlier than t0+8, and CDB src 3 appears at t0+8.
REQ-032 SHALL cover: i_flush at t0+2 after a div issue at t0 -> no strobes at t0+2, o_div_busy=0 and all slots empty at t0+3, and no CDB cycle at t0+8.
REQ-033 SHALL cover, with ISSUE_STALL_CNT_EN: mult_ready held while a slot conflict blocks it for 3 cycles -> o_stall_cnt=3; without the macro, o_stall_cnt stays 0.
